// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
// Module  : lsu_pkg
// Brief   : Shared size encodings, FSM states and alignment check for the LSU.
// Revision: 1.0
// ============================================================================
package lsu_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RMW  = 2'd2,
        ST_DONE = 2'd3
    } lsu_state_t;

    // Size 11 is reported through the same error path as a misaligned access.
    function automatic logic lsu_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        case (size)
            SZ_BYTE: lsu_misaligned = 1'b0;
            SZ_HALF: lsu_misaligned = addr_lo[0];
            SZ_WORD: lsu_misaligned = (addr_lo != 2'b00);
            default: lsu_misaligned = 1'b1;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_lane_align.sv
`default_nettype none
// ============================================================================
// Module  : lsu_lane_align
// Brief   : Little-endian lane extraction (with extension) and sub-word merge.
// Revision: 1.0
// ============================================================================
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [31:0] i_word,
    input  logic [31:0] i_wdata,
    input  logic [1:0]  i_size,
    input  logic [1:0]  i_addr_lo,
    input  logic        i_signed,
    output logic [31:0] o_ext_data,
    output logic [31:0] o_merged
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte     = i_word[{i_addr_lo, 3'b000} +: 8];
        w_half     = i_word[{i_addr_lo[1], 4'b0000} +: 16];
        o_ext_data = '0;
        case (i_size)
            SZ_BYTE: o_ext_data = {{24{i_signed & w_byte[7]}}, w_byte};
            SZ_HALF: o_ext_data = {{16{i_signed & w_half[15]}}, w_half};
            SZ_WORD: o_ext_data = i_word;
            default: o_ext_data = '0;
        endcase
    end

    always_comb begin
        o_merged = i_word;
        case (i_size)
            SZ_BYTE: o_merged[{i_addr_lo, 3'b000} +: 8]     = i_wdata[7:0];
            SZ_HALF: o_merged[{i_addr_lo[1], 4'b0000} +: 16] = i_wdata[15:0];
            SZ_WORD: o_merged = i_wdata;
            default: o_merged = i_word;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module  : load_store_unit
// Brief   : Byte/half/word load-store front end for a word-addressed memory.
// Revision: 1.0
// ============================================================================
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int D_WIDTH = 32,
    parameter int A_WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic               req_we,
    input  logic [1:0]         req_size,
    input  logic               req_signed,
    input  logic [A_WIDTH-1:0] req_addr,
    input  logic [D_WIDTH-1:0] req_wdata,
    output logic               resp_valid,
    output logic [D_WIDTH-1:0] resp_rdata,
    output logic               resp_err,
    output logic               mem_we,
    output logic [A_WIDTH-1:0] mem_w_addr,
    output logic [D_WIDTH-1:0] mem_w_data,
    output logic               mem_re,
    output logic [A_WIDTH-1:0] mem_r_addr,
    input  logic [D_WIDTH-1:0] mem_r_data
);

    lsu_state_t          r_state;
    logic                r_we;
    logic                r_signed;
    logic [1:0]          r_size;
    logic [1:0]          r_addr_lo;
    logic [A_WIDTH-3:0]  r_word_addr;
    logic [D_WIDTH-1:0]  r_wdata;
    logic                r_resp_valid;
    logic                r_resp_err;

    logic                w_accept;
    logic                w_err;
    logic                w_word_store;
    logic [A_WIDTH-1:0]  w_req_aligned;
    logic [A_WIDTH-1:0]  w_rmw_aligned;
    logic [D_WIDTH-1:0]  w_ext_data;
    logic [D_WIDTH-1:0]  w_merged;

    assign req_ready     = (r_state == ST_IDLE) && !rst;
    assign w_accept      = req_valid && req_ready;
    assign w_err         = lsu_misaligned(req_size, req_addr[1:0]);
    assign w_word_store  = req_we && (req_size == SZ_WORD);
    assign w_req_aligned = {req_addr[A_WIDTH-1:2], 2'b00};
    assign w_rmw_aligned = {r_word_addr, 2'b00};

    lsu_lane_align u_lane_align (
        .i_word     (mem_r_data),
        .i_wdata    (r_wdata),
        .i_size     (r_size),
        .i_addr_lo  (r_addr_lo),
        .i_signed   (r_signed),
        .o_ext_data (w_ext_data),
        .o_merged   (w_merged)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_we         <= 1'b0;
            r_signed     <= 1'b0;
            r_size       <= 2'b00;
            r_addr_lo    <= 2'b00;
            r_word_addr  <= '0;
            r_wdata      <= '0;
            r_resp_valid <= 1'b0;
            r_resp_err   <= 1'b0;
        end else begin
            r_resp_valid <= 1'b0;
            r_resp_err   <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (req_valid) begin
                        r_we        <= req_we;
                        r_signed    <= req_signed;
                        r_size      <= req_size;
                        r_addr_lo   <= req_addr[1:0];
                        r_word_addr <= req_addr[A_WIDTH-1:2];
                        r_wdata     <= req_wdata;
                        if (w_err) begin
                            r_state      <= ST_DONE;
                            r_resp_valid <= 1'b1;
                            r_resp_err   <= 1'b1;
                        end else if (!req_we) begin
                            r_state      <= ST_LOAD;
                            r_resp_valid <= 1'b1;
                        end else if (w_word_store) begin
                            r_state      <= ST_DONE;
                            r_resp_valid <= 1'b1;
                        end else begin
                            r_state <= ST_RMW;
                        end
                    end
                end
                ST_LOAD: r_state <= ST_IDLE;
                ST_RMW: begin
                    r_state      <= ST_DONE;
                    r_resp_valid <= 1'b1;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Both ports always carry the same aligned address so the memory's
    // write-through compare sees a consistent pair.
    always_comb begin
        mem_we     = 1'b0;
        mem_re     = 1'b0;
        mem_w_addr = '0;
        mem_r_addr = '0;
        mem_w_data = '0;
        if (w_accept) begin
            mem_w_addr = w_req_aligned;
            mem_r_addr = w_req_aligned;
            if (!w_err) begin
                if (w_word_store) begin
                    mem_we     = 1'b1;
                    mem_w_data = req_wdata;
                end else begin
                    mem_re = 1'b1;
                end
            end
        end else if ((r_state == ST_RMW) && !rst) begin
            mem_we     = 1'b1;
            mem_w_addr = w_rmw_aligned;
            mem_r_addr = w_rmw_aligned;
            mem_w_data = w_merged;
        end
    end

    assign resp_valid = r_resp_valid;
    assign resp_err   = r_resp_err;
    assign resp_rdata = ((r_state == ST_LOAD) && !r_we) ? w_ext_data : '0;

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
// Module  : tb_load_store_unit
// Brief   : Self-checking bench for load_store_unit against a byte-array model.
// Revision: 1.0
// ============================================================================
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_signed = 1'b0;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_we;
    logic [31:0] mem_w_addr;
    logic [31:0] mem_w_data;
    logic        mem_re;
    logic [31:0] mem_r_addr;
    logic [31:0] mem_r_data = 32'h0;

    logic [31:0] tb_mem [0:15];
    logic [7:0]  ref_bytes [0:63];

    int n_cmp = 0;
    int n_bad = 0;

    int          obs_lat, obs_nwe, obs_nre, obs_we_at, obs_re_at;
    int          obs_ready_at, obs_resp_cnt, obs_addr_bad;
    logic [31:0] obs_rdata, obs_we_data, cur_aligned;
    logic        obs_err;

    always #5 clk = ~clk;

    load_store_unit #(.D_WIDTH(32), .A_WIDTH(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_size   (req_size),
        .req_signed (req_signed),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_we     (mem_we),
        .mem_w_addr (mem_w_addr),
        .mem_w_data (mem_w_data),
        .mem_re     (mem_re),
        .mem_r_addr (mem_r_addr),
        .mem_r_data (mem_r_data)
    );

    // Memory stand-in: synchronous write, read data valid the cycle after mem_re.
    always @(posedge clk) begin
        if (mem_we) tb_mem[mem_w_addr[5:2]] <= mem_w_data;
        if (mem_re) mem_r_data <= tb_mem[mem_r_addr[5:2]];
    end

    function automatic logic ref_err(input logic [1:0] sz, input logic [31:0] a);
        return (sz == 2'd3) || (sz == 2'd1 && (a % 2) != 0) || (sz == 2'd2 && (a % 4) != 0);
    endfunction

    function automatic logic [31:0] ref_load(input logic [1:0] sz, input logic sgn, input logic [31:0] a);
        int n = 1 << sz;
        int base = int'(a[5:0]);
        logic [31:0] v = 32'h0;
        for (int i = 0; i < n; i++) v = v | (32'(ref_bytes[base + i]) << (8 * i));
        if (sgn && n < 4 && v[8 * n - 1]) v = v | (32'hFFFF_FFFF << (8 * n));
        return v;
    endfunction

    task automatic ref_store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd);
        int n = 1 << sz;
        int base = int'(a[5:0]);
        for (int i = 0; i < n; i++) ref_bytes[base + i] = wd[8 * i +: 8];
    endtask

    function automatic logic [31:0] ref_word(input logic [31:0] a);
        int b = int'(a[5:2]) * 4;
        return {ref_bytes[b + 3], ref_bytes[b + 2], ref_bytes[b + 1], ref_bytes[b]};
    endfunction

    task automatic sample_cycle(input int c);
        if (mem_we === 1'b1) begin
            obs_nwe++;
            obs_we_at   = c;
            obs_we_data = mem_w_data;
            if (mem_w_addr !== cur_aligned) obs_addr_bad++;
        end
        if (mem_re === 1'b1) begin
            obs_nre++;
            obs_re_at = c;
            if (mem_r_addr !== cur_aligned) obs_addr_bad++;
        end
        if (resp_valid === 1'b1) begin
            obs_resp_cnt++;
            if (obs_lat < 0) begin
                obs_lat   = c;
                obs_rdata = resp_rdata;
                obs_err   = resp_err;
            end
        end
        if (c > 0 && req_ready === 1'b1 && obs_ready_at < 0) obs_ready_at = c;
    endtask

    // Issues one request and records what the DUT does over the following cycles.
    task automatic run_op(input logic we, input logic [1:0] sz, input logic sgn,
                          input logic [31:0] a, input logic [31:0] wd);
        int k = 0;
        obs_lat = -1; obs_nwe = 0; obs_nre = 0; obs_we_at = -1; obs_re_at = -1;
        obs_ready_at = -1; obs_resp_cnt = 0; obs_addr_bad = 0;
        obs_rdata = 32'h0; obs_we_data = 32'h0; obs_err = 1'b0;
        cur_aligned = {a[31:2], 2'b00};
        @(negedge clk);
        while (req_ready !== 1'b1 && k < 10) begin
            @(negedge clk);
            k++;
        end
        req_valid = 1'b1; req_we = we; req_size = sz; req_signed = sgn;
        req_addr = a; req_wdata = wd;
        #1;
        if (req_ready === 1'b1) sample_cycle(0);
        @(posedge clk);
        #1;
        req_valid = 1'b0; req_we = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            sample_cycle(c);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_addr = 32'h10;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if ({req_ready, mem_we, mem_re, resp_valid, resp_err} !== 5'b0 || resp_rdata !== 32'h0) begin
            n_bad++;
            $display("FAIL reset_outputs: got ready=%b we=%b re=%b rv=%b err=%b rdata=%h, want all 0",
                     req_ready, mem_we, mem_re, resp_valid, resp_err, resp_rdata);
        end
        req_valid = 1'b0; req_addr = 32'h0;
        rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (req_ready !== 1'b1) begin
            n_bad++; $display("FAIL ready_after_reset: got %b want 1", req_ready);
        end
        n_cmp++;
        if ({mem_w_addr, mem_r_addr, mem_w_data} !== 96'h0) begin
            n_bad++; $display("FAIL idle_bus_zero: waddr=%h raddr=%h wdata=%h want 0", mem_w_addr, mem_r_addr, mem_w_data);
        end
    endtask

    task automatic test_word_store_load;
        run_op(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF);
        ref_store(2'b10, 32'h10, 32'hDEADBEEF);
        n_cmp++;
        if (obs_nwe != 1 || obs_we_at != 0 || obs_nre != 0 || obs_we_data !== 32'hDEADBEEF) begin
            n_bad++; $display("FAIL sw_write: nwe=%0d at=%0d nre=%0d data=%h want 1/0/0/deadbeef", obs_nwe, obs_we_at, obs_nre, obs_we_data);
        end
        n_cmp++;
        if (obs_lat != 1 || obs_ready_at != 2) begin
            n_bad++; $display("FAIL sw_timing: lat=%0d ready_at=%0d want 1/2", obs_lat, obs_ready_at);
        end
        run_op(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
        n_cmp++;
        if (obs_lat != 1 || obs_rdata !== 32'hDEADBEEF || obs_err !== 1'b0) begin
            n_bad++; $display("FAIL lw_10: lat=%0d rdata=%h err=%b want 1/deadbeef/0", obs_lat, obs_rdata, obs_err);
        end
    endtask

    task automatic test_rmw_store;
        run_op(1'b1, 2'b00, 1'b0, 32'h11, 32'h000000AA);
        ref_store(2'b00, 32'h11, 32'h000000AA);
        n_cmp++;
        if (obs_re_at != 0 || obs_we_at != 1 || obs_we_data !== 32'hDEADAAEF || obs_addr_bad != 0) begin
            n_bad++; $display("FAIL sb_rmw: re_at=%0d we_at=%0d data=%h addr_bad=%0d want 0/1/deadaaef/0", obs_re_at, obs_we_at, obs_we_data, obs_addr_bad);
        end
        n_cmp++;
        if (obs_lat != 2 || obs_ready_at != 3) begin
            n_bad++; $display("FAIL sb_timing: lat=%0d ready_at=%0d want 2/3", obs_lat, obs_ready_at);
        end
        run_op(1'b0, 2'b00, 1'b0, 32'h11, 32'h0);
        n_cmp++;
        if (obs_rdata !== 32'h000000AA) begin
            n_bad++; $display("FAIL lbu_11: got %h want 000000aa", obs_rdata);
        end
        run_op(1'b0, 2'b00, 1'b1, 32'h11, 32'h0);
        n_cmp++;
        if (obs_rdata !== 32'hFFFFFFAA) begin
            n_bad++; $display("FAIL lb_11: got %h want ffffffaa", obs_rdata);
        end
    endtask

    task automatic test_half;
        run_op(1'b1, 2'b01, 1'b0, 32'h12, 32'h00008001);
        ref_store(2'b01, 32'h12, 32'h00008001);
        n_cmp++;
        if (obs_we_data !== 32'h8001AAEF || obs_lat != 2) begin
            n_bad++; $display("FAIL sh_12: data=%h lat=%0d want 8001aaef/2", obs_we_data, obs_lat);
        end
        run_op(1'b0, 2'b01, 1'b1, 32'h12, 32'h0);
        n_cmp++;
        if (obs_rdata !== 32'hFFFF8001) begin
            n_bad++; $display("FAIL lh_12: got %h want ffff8001", obs_rdata);
        end
        run_op(1'b0, 2'b01, 1'b0, 32'h12, 32'h0);
        n_cmp++;
        if (obs_rdata !== 32'h00008001) begin
            n_bad++; $display("FAIL lhu_12: got %h want 00008001", obs_rdata);
        end
        run_op(1'b0, 2'b00, 1'b1, 32'h10, 32'h0);
        n_cmp++;
        if (obs_rdata !== 32'hFFFFFFEF) begin
            n_bad++; $display("FAIL lb_10: got %h want ffffffef", obs_rdata);
        end
    endtask

    task automatic test_errors;
        logic [2:0]  we_v = 3'b010;
        logic [5:0]  sz_v = {2'b11, 2'b01, 2'b10};
        logic [31:0] ad_v [0:2];
        ad_v[0] = 32'h13; ad_v[1] = 32'h11; ad_v[2] = 32'h10;
        for (int i = 0; i < 3; i++) begin
            run_op(we_v[i], sz_v[2 * i +: 2], 1'b1, ad_v[i], 32'hFFFFFFFF);
            n_cmp++;
            if (obs_lat != 1 || obs_err !== 1'b1 || obs_rdata !== 32'h0 || obs_nwe != 0 || obs_nre != 0) begin
                n_bad++;
                $display("FAIL err_case%0d: lat=%0d err=%b rdata=%h nwe=%0d nre=%0d want 1/1/0/0/0",
                         i, obs_lat, obs_err, obs_rdata, obs_nwe, obs_nre);
            end
        end
    endtask

    task automatic test_reset_in_rmw;
        int seen_we = 0;
        int seen_resp = 0;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'b00; req_signed = 1'b0;
        req_addr = 32'h10; req_wdata = 32'h00000055;
        @(posedge clk);
        #1;
        req_valid = 1'b0; req_we = 1'b0; req_addr = 32'h0;
        rst = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (mem_we === 1'b1) seen_we++;
            if (resp_valid === 1'b1) seen_resp++;
            if (c == 2) rst = 1'b0;
        end
        n_cmp++;
        if (seen_we != 0 || seen_resp != 0) begin
            n_bad++; $display("FAIL rst_in_rmw: we_cycles=%0d resp_cycles=%0d want 0/0", seen_we, seen_resp);
        end
        run_op(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
        n_cmp++;
        if (obs_rdata !== 32'h8001AAEF) begin
            n_bad++; $display("FAIL lw_after_rst: got %h want 8001aaef", obs_rdata);
        end
    endtask

    task automatic test_random;
        for (int i = 0; i < 300; i++) begin
            logic        we, sgn, e;
            logic [1:0]  sz;
            logic [31:0] a, wd, exp_rd;
            int          exp_lat;
            we = 1'($urandom_range(0, 1));
            sgn = 1'($urandom_range(0, 1));
            sz = 2'($urandom_range(0, 3));
            a = $urandom();
            wd = $urandom();
            e = ref_err(sz, a);
            exp_lat = (!e && we && sz != 2'd2) ? 2 : 1;
            exp_rd = (!e && !we) ? ref_load(sz, sgn, a) : 32'h0;
            if (!e && we) ref_store(sz, a, wd);
            run_op(we, sz, sgn, a, wd);
            n_cmp++;
            if (obs_lat != exp_lat || obs_resp_cnt != 1 || obs_ready_at != exp_lat + 1) begin
                n_bad++; $display("FAIL rnd%0d_timing: lat=%0d resps=%0d ready_at=%0d want %0d/1/%0d",
                                  i, obs_lat, obs_resp_cnt, obs_ready_at, exp_lat, exp_lat + 1);
            end
            n_cmp++;
            if (obs_rdata !== exp_rd || obs_err !== e) begin
                n_bad++; $display("FAIL rnd%0d_resp: rdata=%h err=%b want %h/%b (we=%b sz=%0d sgn=%b a=%h)",
                                  i, obs_rdata, obs_err, exp_rd, e, we, sz, sgn, a);
            end
            n_cmp++;
            if (obs_nwe != ((!e && we) ? 1 : 0) || obs_nre != ((!e && (!we || sz != 2'd2)) ? 1 : 0) || obs_addr_bad != 0) begin
                n_bad++; $display("FAIL rnd%0d_mem: nwe=%0d nre=%0d addr_bad=%0d (we=%b sz=%0d err=%b)",
                                  i, obs_nwe, obs_nre, obs_addr_bad, we, sz, e);
            end
            if (!e && we) begin
                n_cmp++;
                if (obs_we_data !== ref_word(a)) begin
                    n_bad++; $display("FAIL rnd%0d_wdata: got %h want %h", i, obs_we_data, ref_word(a));
                end
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) tb_mem[i] = 32'h0;
        for (int i = 0; i < 64; i++) ref_bytes[i] = 8'h0;
        test_reset();
        test_word_store_load();
        test_rmw_store();
        test_half();
        test_errors();
        test_reset_in_rmw();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
